// File: rtl/acl_axis_sequencer.sv
// Periodic X/Y/Z register-read scheduler for the PmodACL axis datapath; all outputs are registered.
// A frame is three req/ack reads followed by an atomic update of the three axis outputs.
module acl_axis_sequencer #(
  parameter int         SAMPLE_PERIOD = 100000,
  parameter int         TIMEOUT       = 4096,
  parameter logic [7:0] ADDR_X        = 8'h32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic [9:0]  xAxis,
  output logic [9:0]  yAxis,
  output logic [9:0]  zAxis,
  output logic        frame_valid,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_X,
    S_REQ_Y,
    S_REQ_Z,
    S_UPDATE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rd_req_q, rd_req_d;
  logic [7:0]    rd_addr_q, rd_addr_d;
  logic [9:0]    x_tmp_q, x_tmp_d, y_tmp_q, y_tmp_d, z_tmp_q, z_tmp_d;
  logic [9:0]    x_axis_q, x_axis_d, y_axis_q, y_axis_d, z_axis_q, z_axis_d;
  logic          frame_valid_q, frame_valid_d;
  logic          busy_q, busy_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;
  logic          drop_q, drop_d;
  logic          tick;
  logic          abort;
  logic          rd_data_unused;

  // Only the low 10 bits carry the axis value.
  assign rd_data_unused = ^rd_data[15:10];

  assign tick  = EN && (per_cnt_q == PER_LAST);
  // Once EN has dropped inside a frame the frame is void, even if EN comes back.
  assign abort = drop_q | ~EN;

  always_comb begin
    per_cnt_d     = (!EN || tick) ? '0 : per_cnt_q + 1'b1;
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    rd_req_d      = rd_req_q;
    rd_addr_d     = rd_addr_q;
    x_tmp_d       = x_tmp_q;
    y_tmp_d       = y_tmp_q;
    z_tmp_d       = z_tmp_q;
    x_axis_d      = x_axis_q;
    y_axis_d      = y_axis_q;
    z_axis_d      = z_axis_q;
    frame_valid_d = 1'b0;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q | (tick && (state_q != S_IDLE));
    drop_d        = drop_q | ~EN;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (tick) begin
          state_d   = S_REQ_X;
          rd_addr_d = ADDR_X;
          to_cnt_d  = '0;
        end
      end

      S_REQ_X, S_REQ_Y, S_REQ_Z: begin
        if (!rd_req_q) begin
          // Entry cycle: nothing is outstanding yet, so an abort needs no handshake.
          if (abort) state_d = S_IDLE;
          else       rd_req_d = 1'b1;
        end else if (rd_ack) begin
          // Ack is checked before expiry so a last-cycle ack still lands.
          rd_req_d = 1'b0;
          to_cnt_d = '0;
          case (state_q)
            S_REQ_X: begin
              x_tmp_d   = rd_data[9:0];
              state_d   = S_REQ_Y;
              rd_addr_d = ADDR_X + 8'd2;
            end
            S_REQ_Y: begin
              y_tmp_d   = rd_data[9:0];
              state_d   = S_REQ_Z;
              rd_addr_d = ADDR_X + 8'd4;
            end
            default: begin
              z_tmp_d = rd_data[9:0];
              state_d = S_UPDATE;
            end
          endcase
          if (abort) state_d = S_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          rd_req_d      = 1'b0;
          err_timeout_d = 1'b1;
          x_tmp_d       = '0;
          y_tmp_d       = '0;
          z_tmp_d       = '0;
          to_cnt_d      = '0;
          state_d       = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_UPDATE: begin
        if (!abort) begin
          x_axis_d      = x_tmp_q;
          y_axis_d      = y_tmp_q;
          z_axis_d      = z_tmp_q;
          frame_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      per_cnt_q     <= '0;
      to_cnt_q      <= '0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      x_tmp_q       <= '0;
      y_tmp_q       <= '0;
      z_tmp_q       <= '0;
      x_axis_q      <= '0;
      y_axis_q      <= '0;
      z_axis_q      <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      x_tmp_q       <= x_tmp_d;
      y_tmp_q       <= y_tmp_d;
      z_tmp_q       <= z_tmp_d;
      x_axis_q      <= x_axis_d;
      y_axis_q      <= y_axis_d;
      z_axis_q      <= z_axis_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      drop_q        <= drop_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign xAxis       = x_axis_q;
  assign yAxis       = y_axis_q;
  assign zAxis       = z_axis_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_acl_axis_sequencer.sv
// Bench for acl_axis_sequencer: a behavioural SPI-slave responder plus a table of
// per-frame scenarios, followed by hand-written EN-drop and mid-handshake reset sequences.
module tb_acl_axis_sequencer;

  localparam int         SP = 64;
  localparam int         TO = 32;
  localparam logic [7:0] AX = 8'h32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN  = 1'b0;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_ack  = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic [9:0]  xAxis, yAxis, zAxis;
  logic        frame_valid, busy, err_timeout, err_overrun;

  acl_axis_sequencer #(.SAMPLE_PERIOD(SP), .TIMEOUT(TO), .ADDR_X(AX)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .xAxis(xAxis), .yAxis(yAxis), .zAxis(zAxis),
    .frame_valid(frame_valid), .busy(busy),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 CLK = ~CLK;

  // Slave configuration (written by the stimulus process only).
  logic [15:0] dat_x = 0, dat_y = 0, dat_z = 0;
  int          dl_x = 1, dl_y = 1, dl_z = 1;
  bit          gap_ack = 1'b0;
  bit          log_clr = 1'b0;

  // Slave state and logs (written by the slave process only).
  int          hi_cnt = 0, n_req = 0, max_hi = 0, unstable = 0, fv_cnt = 0;
  logic [7:0]  cur_addr = 0;
  logic [7:0]  addr_log [8];

  int tests = 0, fails = 0;

  // Acks on the N-th consecutive cycle rd_req is high (N=0: never); optional stray acks in gaps.
  always @(negedge CLK) begin
    int dl;
    if (log_clr) begin
      n_req = 0; max_hi = 0; unstable = 0;
    end
    if (rd_req) begin
      if (hi_cnt == 0) begin
        if (n_req < 8) addr_log[n_req] = rd_addr;
        n_req++;
        cur_addr = rd_addr;
      end else if (rd_addr != cur_addr) begin
        unstable++;
      end
      hi_cnt++;
      if (hi_cnt > max_hi) max_hi = hi_cnt;
      dl = (rd_addr == AX) ? dl_x : (rd_addr == AX + 8'd2) ? dl_y : dl_z;
      rd_ack  = (hi_cnt == dl);
      rd_data = (rd_addr == AX) ? dat_x : (rd_addr == AX + 8'd2) ? dat_y : dat_z;
    end else begin
      hi_cnt  = 0;
      rd_ack  = gap_ack && busy;
      rd_data = 16'h02DB;
    end
  end

  always @(negedge CLK) if (frame_valid) fv_cnt++;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge CLK);
    while (busy && k < 300) begin
      @(negedge CLK);
      k++;
    end
    check(nm, int'(busy), 0);
  endtask

  task automatic clear_logs();
    log_clr = 1'b1;
    @(negedge CLK);
    #1 log_clr = 1'b0;
  endtask

  typedef struct {
    logic [15:0] dat_x, dat_y, dat_z;
    int          dl_x, dl_y, dl_z;
    bit          gap;
    int          win;
    logic [9:0]  ex, ey, ez;
    int          efv;
    bit          eto, eov;
    int          enreq, emaxhi;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int k, fv0;
    string tag;

    //          dat_x     dat_y     dat_z    dly x/y/z  gap win  ex      ey      ez    fv to ov nreq maxhi
    vecs[0] = '{16'h03FF, 16'h0001, 16'h0200, 5, 5, 5, 1'b0, 120, 10'h3FF, 10'h001, 10'h200, 1, 1'b0, 1'b0, 3, 5};
    vecs[1] = '{16'hFC01, 16'hABCD, 16'h0155, 1, 2, 3, 1'b1, 120, 10'h001, 10'h3CD, 10'h155, 1, 1'b0, 1'b0, 3, 3};
    vecs[2] = '{16'h0000, 16'h02AA, 16'h7E00, TO, 2, 2, 1'b0, 120, 10'h000, 10'h2AA, 10'h200, 1, 1'b0, 1'b0, 3, TO};
    vecs[3] = '{16'h0123, 16'h0123, 16'h0123, 0, 0, 0, 1'b0, 120, 10'h000, 10'h2AA, 10'h200, 0, 1'b1, 1'b0, 1, TO};
    vecs[4] = '{16'h0111, 16'h0222, 16'h0333, 30, 30, 30, 1'b0, 186, 10'h111, 10'h222, 10'h333, 1, 1'b1, 1'b1, 3, 30};

    // Reset state.
    #22;
    check("rst_rd_req", int'(rd_req), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_axes", int'({xAxis, yAxis, zAxis}), 0);
    check("rst_flags", int'({frame_valid, busy, err_timeout, err_overrun}), 0);
    RST = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("v%0d", i);
      @(posedge CLK); #1 EN = 1'b0;
      wait_idle({tag, "_pre_idle"});
      dat_x = vecs[i].dat_x; dat_y = vecs[i].dat_y; dat_z = vecs[i].dat_z;
      dl_x = vecs[i].dl_x;   dl_y = vecs[i].dl_y;   dl_z = vecs[i].dl_z;
      gap_ack = vecs[i].gap;
      clear_logs();
      fv0 = fv_cnt;
      @(posedge CLK); #1 EN = 1'b1;
      repeat (vecs[i].win) @(negedge CLK);
      check({tag, "_busy_end"}, int'(busy), 0);
      @(posedge CLK); #1 EN = 1'b0;
      wait_idle({tag, "_idle"});
      repeat (3) @(negedge CLK);
      gap_ack = 1'b0;
      check({tag, "_x"}, int'(xAxis), int'(vecs[i].ex));
      check({tag, "_y"}, int'(yAxis), int'(vecs[i].ey));
      check({tag, "_z"}, int'(zAxis), int'(vecs[i].ez));
      check({tag, "_frames"}, fv_cnt - fv0, vecs[i].efv);
      check({tag, "_err_timeout"}, int'(err_timeout), int'(vecs[i].eto));
      check({tag, "_err_overrun"}, int'(err_overrun), int'(vecs[i].eov));
      check({tag, "_n_req"}, n_req, vecs[i].enreq);
      check({tag, "_req_high_max"}, max_hi, vecs[i].emaxhi);
      check({tag, "_addr_stable"}, unstable, 0);
      for (int j = 0; j < n_req && j < 8; j++)
        check($sformatf("%s_addr%0d", tag, j), int'(addr_log[j]), int'(AX + 8'(2 * (j % 3))));
    end

    // EN dropped while the Y request is outstanding: held until ack, then idle, frame discarded.
    dat_x = 16'h0011; dat_y = 16'h0022; dat_z = 16'h0033;
    dl_x = 2; dl_y = 20; dl_z = 2;
    clear_logs();
    fv0 = fv_cnt;
    @(posedge CLK); #1 EN = 1'b1;
    k = 0;
    while (!(rd_req && rd_addr == AX + 8'd2) && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("endrop_reach_req_y", int'(rd_req && rd_addr == AX + 8'd2), 1);
    @(posedge CLK); #1 EN = 1'b0;
    wait_idle("endrop_idle");
    repeat (150) @(negedge CLK);
    check("endrop_frames", fv_cnt - fv0, 0);
    check("endrop_req_held", max_hi, 20);
    check("endrop_n_req", n_req, 2);
    check("endrop_x_kept", int'(xAxis), 10'h111);
    check("endrop_busy", int'(busy), 0);

    // Reset while the Z request is outstanding, then restart from ADDR_X on the first tick.
    dat_x = 16'h012A; dat_y = 16'h00F0; dat_z = 16'h03C3;
    dl_x = 3; dl_y = 3; dl_z = 3;
    @(posedge CLK); #1 EN = 1'b1;
    k = 0;
    while (!(rd_req && rd_addr == AX + 8'd4) && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("rstmid_reach_req_z", int'(rd_req && rd_addr == AX + 8'd4), 1);
    #1 RST = 1'b0;
    #1;
    check("rstmid_rd_req", int'(rd_req), 0);
    check("rstmid_axes", int'({xAxis, yAxis, zAxis}), 0);
    check("rstmid_flags", int'({frame_valid, busy, err_timeout, err_overrun}), 0);
    clear_logs();
    RST = 1'b1;
    k = 0;
    while (!rd_req && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("rstmid_first_req_cycle", k, SP + 1);
    check("rstmid_first_addr", int'(rd_addr), int'(AX));
    k = 0;
    while (!frame_valid && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("rstmid_frame_seen", int'(frame_valid), 1);
    check("rstmid_xyz", int'({xAxis, yAxis, zAxis}), int'({10'h12A, 10'h0F0, 10'h3C3}));
    check("rstmid_n_req", n_req, 3);
    check("rstmid_err_timeout", int'(err_timeout), 0);
    @(posedge CLK); #1 EN = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
